uart_rx_fifo: RTL

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each received byte with its parity- and framing-error status on the receiver's one-cycle data-ready strobe. Presents the bytes to the bus/host side in first-word-fall-through order. Tracks occupancy, and flags overflow when bytes arrive faster than the host drains them.

---
 rtl/uart_rx_fifo.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer with per-byte parity/frame status and a sticky overflow flag.
// Optional host-interrupt watermark output is built when UART_RX_FIFO_WATERMARK_EN is defined.
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
`ifdef UART_RX_FIFO_WATERMARK_EN
   ,parameter int WATERMARK = DEPTH - 4
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_valid,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_parity_err,
   input  logic                       wr_frame_err,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_parity_err,
   output logic                       rd_frame_err,
   output logic                       rd_valid,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       overflow_clr
`ifdef UART_RX_FIFO_WATERMARK_EN
   ,output logic                      watermark
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + 2;

   // Entry layout: {frame_err, parity_err, data}
   logic [EW-1:0] mem_r [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          overflow_r;

   logic          empty_s;
   logic          full_s;
   logic          wr_accept_s;
   logic          rd_accept_s;
   logic          ovf_set_s;
   logic [EW-1:0] head_s;

   assign empty_s     = (wr_ptr_r == rd_ptr_r);
   assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   // A pop on a full FIFO frees the slot the incoming byte lands in.
   assign wr_accept_s = wr_valid && (!full_s || rd_en);
   assign rd_accept_s = rd_en && !empty_s;
   assign ovf_set_s   = wr_valid && full_s && !rd_en;
   assign head_s      = mem_r[rd_ptr_r[AW-1:0]];

   // Storage array write; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {wr_frame_err, wr_parity_err, wr_data};
      end
   end

   // Write and read pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_accept_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (rd_accept_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Sticky overflow; a new drop in the clear cycle keeps it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
         overflow_r <= 1'b1;
      end else if (overflow_clr) begin
         overflow_r <= 1'b0;
      end
   end

   // Head-of-queue presentation, forced to zero while empty.
   always_comb begin
      rd_data       = '0;
      rd_parity_err = 1'b0;
      rd_frame_err  = 1'b0;
      if (empty_s) begin
         rd_data       = '0;
         rd_parity_err = 1'b0;
         rd_frame_err  = 1'b0;
      end else begin
         rd_data       = head_s[DATA_W-1:0];
         rd_parity_err = head_s[DATA_W];
         rd_frame_err  = head_s[DATA_W+1];
      end
   end

   assign rd_valid = !empty_s;
   assign empty    = empty_s;
   assign full     = full_s;
   assign count    = wr_ptr_r - rd_ptr_r;
   assign overflow = overflow_r;

`ifdef UART_RX_FIFO_WATERMARK_EN
   logic watermark_r;

   // Registered occupancy threshold used as the host interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         watermark_r <= 1'b0;
      end else begin
         watermark_r <= (count >= (AW+1)'(WATERMARK));
      end
   end

   assign watermark = watermark_r;
`endif

endmodule
